load_store_unit: RTL and testbench
==================================

# load_store_unit

Bridges the execute stage and `data_memory`. It accepts one byte, halfword or word load/store request at a time over a valid/ready handshake and converts the byte address to a word index. Loads get lane extraction and sign/zero extension; sub-word stores are done as read-modify-write, because the word-wide memory has no byte enables. It drives `data_memory`'s Address/Write_data/MemWrite/MemRead and returns load data toward write-back.

## Interface
- `ADDR_WIDTH`, 32: byte-address width; memory word index is `ADDR_WIDTH` wide.
- `DATA_WIDTH`, 32: word width; lane logic is fixed for 32.
- `clkn`  in  1  clock; this block updates on the rising edge of `clkn`, while `data_memory` samples on the falling edge.
- `rstn`  in  1  reset; synchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE (and not in reset).
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads only: zero-extend instead of sign-extend.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  DATA_WIDTH  store data; the low byte/half is used for sub-word stores.
- `resp_valid`  out  1  one-cycle completion pulse, for loads and stores.
- `resp_rdata`  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- `resp_error`  out  1  misaligned or illegal size; qualified by `resp_valid`.
- `mem_address`  out  ADDR_WIDTH  word index = `{2'b00, addr[ADDR_WIDTH-1:2]}`.
- `mem_write_data`  out  DATA_WIDTH  to `Write_data`.
- `mem_write`  out  1  to `MemWrite`.
- `mem_read`  out  1  to `MemRead`.
- `mem_read_data`  in  DATA_WIDTH  from `Read_data`.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE, on `req_valid`:
  - Capture all request fields.
  - Error if size = 11, if half with `addr[0]`=1, or if word with `addr[1:0]`≠0 → RESP with error set. No memory access occurs.
  - Load, or sub-word store → READ.
  - Word store → WRITE.
- READ: `mem_read`=1.
  - Load: extract the lane, extend, register into `resp_rdata` → RESP.
  - Sub-word store: merge the captured data into the read word → WRITE.
- WRITE: `mem_write`=1, `mem_write_data` = merged word (or `req_wdata` for a word store) → RESP.
- RESP: `resp_valid`=1 for exactly one cycle → IDLE.
- Lane rules (little-endian): byte lane = `addr[1:0]`; lane 0 is bits [7:0]. Half lane = `addr[1]`; 0 is [15:0].
- Extension: sign-extend by default; zero-extend when `req_unsigned`. Word loads ignore `req_unsigned`.
- `mem_read` and `mem_write` are decoded from the state register only. They are never both high, and never glitch at the falling edge.
- `mem_address` and `mem_write_data` are registered and hold their values outside READ/WRITE.
- No request is accepted outside IDLE. The request fields are don't-care when `req_ready`=0.

## Timing
- Cycle 0 is the IDLE cycle in which `req_valid`&`req_ready` is sampled.
- Load: READ in cycle 1; `data_memory` latches `Read_data` on the cycle-1 falling edge; `resp_valid` in cycle 2.
- Word store: WRITE in cycle 1 (memory writes on the falling edge); `resp_valid` in cycle 2.
- Sub-word store: READ cycle 1, WRITE cycle 2, `resp_valid` cycle 3.
- Error: `resp_valid`=`resp_error`=1 in cycle 1.
- Back-to-back: the next request is accepted in the cycle after RESP. Throughput is one op per 2–4 cycles.
- Reset (`rstn`=0 at a rising edge), regardless of state:
  - State → IDLE.
  - `resp_valid`, `resp_error`, `mem_read`, `mem_write` → 0.
  - `resp_rdata`, `mem_address`, `mem_write_data` → 0.
  - `req_ready`=0 while `rstn`=0.
  - An in-flight op is abandoned with no response.
  - A sub-word store reset during READ never writes memory.
- Address wrap: the top word index (byte `0xFFFF_FFFC`–`FFFF`) is handled normally. There is no carry across the word boundary.

## Test plan
- Preload word index 0x40 = 0x8899AABB:
  - lb @0x101 → `resp_rdata`=0xFFFFFFAA in cycle 2.
  - lbu @0x101 → 0x000000AA.
  - lh @0x102 → 0xFFFF8899.
  - lhu @0x102 → 0x00008899.
- Same preload; sb data 0x1234565C @0x103:
  - One `mem_read` cycle, then one `mem_write` cycle with `mem_address`=0x40.
  - Word becomes 0x5C99AABB.
  - `resp_valid` in cycle 3 with `resp_rdata`=0.
- sw 0xDEADBEEF @0x200:
  - `mem_write` in cycle 1 with index 0x80; `mem_read` never asserted.
  - A following lw @0x200 returns 0xDEADBEEF.
- lw @0x102, lh @0x001, and size 11:
  - Each gives `resp_valid`=`resp_error`=1 in cycle 1.
  - `mem_read`/`mem_write` stay 0; `resp_rdata`=0.
- sh 0xCAFE @0x40, with `rstn` pulsed low during READ:
  - Memory is unchanged and no `resp_valid` is produced.
  - All outputs are 0 the cycle after reset.
  - `req_ready`=1 once `rstn`=1, and the next lw completes normally.
- Hold `req_valid` high for 4 alternating lw/sw ops:
  - Each is accepted only in IDLE; no request is lost or duplicated.
  - Responses come in order.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store bridge to a word-wide data memory
//
// Ports:
//   clkn, rstn            rising-edge clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE, out of reset)
//   req_write, req_size, req_unsigned, req_addr, req_wdata   request fields
//   resp_valid            one-cycle completion pulse
//   resp_rdata            extended load data (0 for stores and errors)
//   resp_error            misaligned / illegal size, qualified by resp_valid
//   mem_address           registered word index into data_memory
//   mem_write_data        registered write word
//   mem_write, mem_read   state-decoded memory strobes
//   mem_read_data         word returned by data_memory

module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clkn,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state;
    state_t      state_next;

    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;   // only the low half is ever merged; word stores bypass it

    logic                  req_fire;
    logic                  req_err;
    logic [7:0]            lane_byte;
    logic [15:0]           lane_half;
    logic [DATA_WIDTH-1:0] load_value;
    logic [DATA_WIDTH-1:0] merged;

    assign req_ready  = (state == IDLE) && rstn;
    assign req_fire   = req_valid && req_ready;

    // Strobes come straight from the state register so they are stable
    // across the falling edge where data_memory samples them.
    assign mem_read   = (state == READ);
    assign mem_write  = (state == WRITE);
    assign resp_valid = (state == RESP);

    assign req_err = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    always_ff @(posedge clkn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_fire) begin
                    if (req_err)
                        state_next = RESP;
                    else if (!req_write || req_size != 2'b10)
                        state_next = READ;   // loads and read-modify-write stores
                    else
                        state_next = WRITE;
                end
            end
            READ:    state_next = r_write ? WRITE : RESP;
            WRITE:   state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    // Little-endian lane selection and extension of the returned word.
    always_comb begin
        lane_byte = 8'h00;
        case (r_lane)
            2'd0:    lane_byte = mem_read_data[7:0];
            2'd1:    lane_byte = mem_read_data[15:8];
            2'd2:    lane_byte = mem_read_data[23:16];
            default: lane_byte = mem_read_data[31:24];
        endcase
        lane_half = r_lane[1] ? mem_read_data[31:16] : mem_read_data[15:0];

        case (r_size)
            2'b00:   load_value = r_unsigned ? {{(DATA_WIDTH-8){1'b0}}, lane_byte}
                                             : {{(DATA_WIDTH-8){lane_byte[7]}}, lane_byte};
            2'b01:   load_value = r_unsigned ? {{(DATA_WIDTH-16){1'b0}}, lane_half}
                                             : {{(DATA_WIDTH-16){lane_half[15]}}, lane_half};
            default: load_value = mem_read_data;
        endcase
    end

    // Sub-word store: splice the captured byte/half into the word just read.
    always_comb begin
        merged = mem_read_data;
        if (r_size == 2'b00) begin
            case (r_lane)
                2'd0:    merged[7:0]   = r_wdata[7:0];
                2'd1:    merged[15:8]  = r_wdata[7:0];
                2'd2:    merged[23:16] = r_wdata[7:0];
                default: merged[31:24] = r_wdata[7:0];
            endcase
        end else if (r_lane[1]) begin
            merged[31:16] = r_wdata;
        end else begin
            merged[15:0] = r_wdata;
        end
    end

    always_ff @(posedge clkn) begin
        if (!rstn) begin
            r_write        <= 1'b0;
            r_size         <= 2'b00;
            r_unsigned     <= 1'b0;
            r_lane         <= 2'b00;
            r_wdata        <= '0;
            resp_rdata     <= '0;
            resp_error     <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_lane     <= req_addr[1:0];
                        r_wdata    <= req_wdata[15:0];
                        resp_error <= req_err;
                        resp_rdata <= '0;
                        if (!req_err)
                            mem_address <= {2'b00, req_addr[ADDR_WIDTH-1:2]};
                        if (!req_err && req_write && req_size == 2'b10)
                            mem_write_data <= req_wdata;
                    end
                end
                READ: begin
                    if (r_write)
                        mem_write_data <= merged;
                    else
                        resp_rdata <= load_value;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a falling-edge memory model

module tb_load_store_unit;

    logic        clkn = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data = 32'h0;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clkn(clkn), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    always #5 clkn = ~clkn;

    // data_memory: samples strobes on the falling edge
    logic [31:0] mem [logic [31:0]];
    always @(negedge clkn) begin
        if (mem_write) mem[mem_address] = mem_write_data;
        if (mem_read)  mem_read_data <= mem.exists(mem_address) ? mem[mem_address] : 32'h0;
    end

    function automatic logic [31:0] mem_peek(input logic [31:0] idx);
        return mem.exists(idx) ? mem[idx] : 32'h0;
    endfunction

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nr;
        int          nw;
        logic [31:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge clkn) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: tracks acceptance, memory strobes and pops the scoreboard on resp_valid.
    always @(negedge clkn) begin
        if (!rstn) begin
            acc_q.delete();
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (mem_read && mem_write) check("strobe_overlap", 32'd1, 32'd0);
            if (mem_read) begin
                rd_cnt++;
                if (exp_q.size() > 0) check("read_addr", mem_address, exp_q[0].idx);
            end
            if (mem_write) begin
                wr_cnt++;
                if (exp_q.size() > 0) check("write_addr", mem_address, exp_q[0].idx);
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    int   a;
                    e = exp_q.pop_front();
                    a = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_error", {31'd0, resp_error}, {31'd0, e.err});
                    check("resp_latency", cyc - a, e.lat);
                    check("read_cycles", rd_cnt, e.nr);
                    check("write_cycles", wr_cnt, e.nw);
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
            if (req_valid && req_ready) acc_q.push_back(cyc);
        end
    end

    // Drives one request, leaves req_valid high; returns at posedge+1 after acceptance.
    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee,
                         input int lat, input int nr, input int nw);
        exp_t e;
        int   t;
        e.rdata = er; e.err = ee; e.lat = lat; e.nr = nr; e.nw = nw;
        e.idx = {2'b00, a[31:2]};
        exp_q.push_back(e);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        t = 0;
        @(negedge clkn);
        while (!req_ready && t < 20) begin
            @(negedge clkn);
            t++;
        end
        if (!req_ready) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clkn);
        #1;
    endtask

    task automatic load(input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] er);
        issue(1'b0, sz, u, a, 32'h0, er, 1'b0, 2, 1, 0);
    endtask

    task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        if (sz == 2'b10) issue(1'b1, sz, 1'b0, a, wd, 32'h0, 1'b0, 2, 0, 1);
        else             issue(1'b1, sz, 1'b0, a, wd, 32'h0, 1'b0, 3, 1, 1);
    endtask

    task automatic bad(input logic w, input logic [1:0] sz, input logic [31:0] a);
        issue(w, sz, 1'b0, a, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    endtask

    task automatic drain;
        int t;
        req_valid = 1'b0;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clkn);
            t++;
        end
        check("drain", exp_q.size(), 32'd0);
        @(posedge clkn);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, {27'd0, resp_valid, resp_error, mem_read, mem_write, req_ready}, 32'd0);
        check({tag, "_rdata"}, resp_rdata, 32'h0);
        check({tag, "_addr"}, mem_address, 32'h0);
        check({tag, "_wdata"}, mem_write_data, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        mem[32'h40] = 32'h8899AABB;
        mem[32'h10] = 32'h11223344;
        mem[32'hC0] = 32'hA5A5A5A5;
        mem[32'h50] = 32'h00000000;

        repeat (3) @(posedge clkn);
        #1;
        check_all_zero("reset");
        rstn = 1'b1;
        @(negedge clkn);
        check("ready_after_reset", {31'd0, req_ready}, 32'd1);
        @(posedge clkn);
        #1;

        // lane extraction and extension
        load(2'b00, 1'b0, 32'h101, 32'hFFFFFFAA);
        load(2'b00, 1'b1, 32'h101, 32'h000000AA);
        load(2'b01, 1'b0, 32'h102, 32'hFFFF8899);
        load(2'b01, 1'b1, 32'h102, 32'h00008899);
        load(2'b00, 1'b0, 32'h100, 32'hFFFFFFBB);
        load(2'b00, 1'b1, 32'h103, 32'h00000088);
        load(2'b01, 1'b0, 32'h100, 32'hFFFFAABB);
        load(2'b10, 1'b1, 32'h100, 32'h8899AABB);
        drain();

        // sub-word stores (read-modify-write)
        store(2'b00, 32'h103, 32'h1234565C);
        drain();
        check("sb_word", mem_peek(32'h40), 32'h5C99AABB);
        store(2'b01, 32'h142, 32'h1234CAFE);
        drain();
        check("sh_word", mem_peek(32'h50), 32'hCAFE0000);

        // word store then load back
        store(2'b10, 32'h200, 32'hDEADBEEF);
        load(2'b10, 1'b0, 32'h200, 32'hDEADBEEF);
        drain();

        // top word index, no carry past the word
        store(2'b10, 32'hFFFFFFFC, 32'h13579BDF);
        load(2'b00, 1'b1, 32'hFFFFFFFF, 32'h00000013);
        load(2'b01, 1'b0, 32'hFFFFFFFE, 32'h00001357);
        drain();

        // error cases: no memory traffic, one-cycle response
        bad(1'b0, 2'b10, 32'h102);
        bad(1'b0, 2'b01, 32'h001);
        bad(1'b0, 2'b11, 32'h100);
        bad(1'b1, 2'b01, 32'h003);
        drain();

        // sh abandoned by reset during READ
        req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h0000CAFE; req_valid = 1'b1;
        @(negedge clkn);
        @(posedge clkn);
        #1;
        req_valid = 1'b0;
        rstn = 1'b0;
        @(negedge clkn);
        check("abandon_in_read", {31'd0, mem_read}, 32'd1);
        @(posedge clkn);
        #1;
        check_all_zero("mid_reset");
        rstn = 1'b1;
        @(negedge clkn);
        check("ready_after_abort", {31'd0, req_ready}, 32'd1);
        repeat (4) @(posedge clkn);
        #1;
        check("abandon_mem", mem_peek(32'h10), 32'h11223344);
        load(2'b10, 1'b0, 32'h40, 32'h11223344);
        drain();

        // req_valid held high across alternating lw/sw
        load(2'b10, 1'b0, 32'h300, 32'hA5A5A5A5);
        store(2'b10, 32'h304, 32'h01020304);
        load(2'b10, 1'b0, 32'h304, 32'h01020304);
        store(2'b10, 32'h300, 32'h0BADF00D);
        drain();
        check("stream_mem0", mem_peek(32'hC0), 32'h0BADF00D);
        check("stream_mem1", mem_peek(32'hC1), 32'h01020304);

        repeat (3) @(posedge clkn);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
